// File: rtl/shift_ctrl_piso.sv
// Parallel-in/serial-out shift controller: takes one N-bit word over valid/ready
// and emits it one bit per shift_tick, pulsing done after the last bit.
module shift_ctrl_piso #(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         shift_tick,
    input  logic         abort,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [N-1:0]  r_shreg;
    logic [N-1:0]  w_shreg_d;
    logic [N-1:0]  w_shreg_shifted;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] w_bit_cnt_d;
    logic          w_out_bit;

    // Shift toward the output end, back-filling with zero.
    if (MSB_FIRST) begin : g_msb
        assign w_shreg_shifted = {r_shreg[N-2:0], 1'b0};
        assign w_out_bit       = r_shreg[N-1];
    end else begin : g_lsb
        assign w_shreg_shifted = {1'b0, r_shreg[N-1:1]};
        assign w_out_bit       = r_shreg[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_shreg   <= w_shreg_d;
            r_bit_cnt <= w_bit_cnt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_bit_cnt_d = r_bit_cnt;
        unique case (r_state)
            StIdle: begin
                // abort outranks acceptance so a word offered alongside it is dropped
                if (in_valid && !abort) begin
                    w_state_d   = StShift;
                    w_shreg_d   = in_data;
                    w_bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (abort) begin
                    w_state_d   = StIdle;
                    w_shreg_d   = '0;
                    w_bit_cnt_d = '0;
                end else if (shift_tick) begin
                    w_shreg_d = w_shreg_shifted;
                    if (r_bit_cnt == LastCnt) begin
                        w_state_d = StDone;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                if (abort) begin
                    w_shreg_d   = '0;
                    w_bit_cnt_d = '0;
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_shreg_d   = '0;
                w_bit_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        in_ready   = (r_state == StIdle);
        sout_valid = (r_state == StShift);
        busy       = (r_state == StShift) || (r_state == StDone);
        done       = (r_state == StDone);
        sout       = (r_state == StShift) ? w_out_bit : 1'b0;
    end

endmodule

// File: tb/tb_shift_ctrl_piso.sv
// Bench for shift_ctrl_piso: fixed vector table, hand-written corner sequences
// and a randomized run against a word/bit-index reference model.
module tb_shift_ctrl_piso;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         shift_tick = 1'b0;
    logic         abort = 1'b0;

    logic in_ready, sout, sout_valid, busy, done;
    logic in_ready_l, sout_l, sout_valid_l, busy_l, done_l;

    always #5 clk = ~clk;

    shift_ctrl_piso #(.N(N), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift_tick(shift_tick), .abort(abort), .sout(sout),
        .sout_valid(sout_valid), .busy(busy), .done(done)
    );

    shift_ctrl_piso #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .shift_tick(shift_tick), .abort(abort), .sout(sout_l),
        .sout_valid(sout_valid_l), .busy(busy_l), .done(done_l)
    );

    int total = 0;
    int bad = 0;

    // Reference model: phase 0=idle, 1=sending, 2=done; m_idx = bits already sent.
    int           m_phase = 0;
    logic [N-1:0] m_word = '0;
    int           m_idx = 0;

    typedef struct {
        logic         v;
        logic [N-1:0] d;
        logic         t;
        logic         a;
        logic         e_sout;
        logic         e_sv;
        logic         e_rdy;
        logic         e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void model_step();
        case (m_phase)
            0: if (in_valid && !abort) begin
                m_phase = 1;
                m_word  = in_data;
                m_idx   = 0;
            end
            1: if (abort) begin
                m_phase = 0;
            end else if (shift_tick) begin
                if (m_idx == N - 1) m_phase = 2;
                else m_idx++;
            end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic check_model(input int cyc);
        logic e_msb, e_lsb;
        e_msb = (m_phase == 1) ? m_word[N-1-m_idx] : 1'b0;
        e_lsb = (m_phase == 1) ? m_word[m_idx] : 1'b0;
        check($sformatf("rnd%0d in_ready", cyc), {31'd0, in_ready}, {31'd0, m_phase == 0});
        check($sformatf("rnd%0d sout_valid", cyc), {31'd0, sout_valid}, {31'd0, m_phase == 1});
        check($sformatf("rnd%0d busy", cyc), {31'd0, busy}, {31'd0, m_phase != 0});
        check($sformatf("rnd%0d done", cyc), {31'd0, done}, {31'd0, m_phase == 2});
        check($sformatf("rnd%0d sout_msb", cyc), {31'd0, sout}, {31'd0, e_msb});
        check($sformatf("rnd%0d sout_lsb", cyc), {31'd0, sout_l}, {31'd0, e_lsb});
    endtask

    // Drive inputs for one clock, step the model at the edge, return at the negedge.
    task automatic cycle(input logic v, input logic [N-1:0] d, input logic t, input logic a);
        in_valid   = v;
        in_data    = d;
        shift_tick = t;
        abort      = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]   stream;
        logic [N-1:0] rd;
        int nbits, ndone, rdy_w1;
        bit acc1, done1;

        // Word 4'hB with tick every clock, then abort after two bits of 4'hF and 4'h3.
        tbl.push_back('{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // Reset held, then released between edges.
        repeat (2) @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst sout_valid", {31'd0, sout_valid}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst sout", {31'd0, sout}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].a);
            check($sformatf("row%0d sout", i), {31'd0, sout}, {31'd0, tbl[i].e_sout});
            check($sformatf("row%0d sout_valid", i), {31'd0, sout_valid}, {31'd0, tbl[i].e_sv});
            check($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            check($sformatf("row%0d done", i), {31'd0, done}, {31'd0, tbl[i].e_done});
        end

        // LSB-first, tick every second clock: each bit held two clocks.
        stream = '0;
        nbits  = 0;
        ndone  = 0;
        cycle(1'b1, 4'hB, 1'b0, 1'b0);
        if (sout_valid_l) begin stream = {stream[6:0], sout_l}; nbits++; end
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 4'h0, k[0] == 1'b1, 1'b0);
            if (sout_valid_l) begin stream = {stream[6:0], sout_l}; nbits++; end
            if (done_l) ndone++;
        end
        check("lsb stream", {24'd0, stream}, 32'hF3);
        check("lsb samples", nbits, 8);
        check("lsb done pulses", ndone, 1);

        // Back-to-back with in_valid held high: second word waits for IDLE after DONE.
        stream = '0;
        nbits  = 0;
        rdy_w1 = 0;
        acc1   = 1'b0;
        done1  = 1'b0;
        for (int c = 0; c < 40 && nbits < 8; c++) begin
            cycle(1'b1, acc1 ? 4'h5 : 4'hA, 1'b1, 1'b0);
            if (sout_valid) begin stream = {stream[6:0], sout}; nbits++; acc1 = 1'b1; end
            if (acc1 && !done1 && in_ready) rdy_w1++;
            if (done) done1 = 1'b1;
        end
        check("b2b stream", {24'd0, stream}, 32'hA5);
        check("b2b bits", nbits, 8);
        check("b2b ready during word1", rdy_w1, 0);
        repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("b2b idle after", {31'd0, in_ready}, 32'd1);

        // in_data changes while the word is in flight.
        stream = '0;
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        stream = {stream[6:0], sout};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
            stream = {stream[6:0], sout};
        end
        check("hold data stream", {24'd0, stream}, 32'h0C);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("hold data done", {31'd0, done}, 32'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'h9, 1'b0, 1'b1);
        check("idle abort in_ready", {31'd0, in_ready}, 32'd1);
        check("idle abort sout_valid", {31'd0, sout_valid}, 32'd0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("idle abort still idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset between edges in the middle of a word.
        cycle(1'b1, 4'hF, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("pre-arst busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        m_phase = 0;
        #1;
        check("arst in_ready", {31'd0, in_ready}, 32'd1);
        check("arst sout_valid", {31'd0, sout_valid}, 32'd0);
        check("arst sout", {31'd0, sout}, 32'd0);
        check("arst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("arst no resume", {31'd0, sout_valid}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rd = N'($urandom);
            cycle(1'($urandom_range(0, 1)), rd, ($urandom % 10) < 6, ($urandom % 20) == 0);
            check_model(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
